// File: rtl/intc_pkg.sv
// Shared definitions for the intc_pc interrupt controller.
// Contents: register word offsets, FSM state encoding, CTRL bit positions.
package intc_pkg;

  // Register word offsets on the A bus
  localparam logic [1:0] INTC_PEND = 2'd0;
  localparam logic [1:0] INTC_MASK = 2'd1;
  localparam logic [1:0] INTC_VEC  = 2'd2;
  localparam logic [1:0] INTC_CTRL = 2'd3;

  // CTRL register: global enable bit
  localparam int unsigned CTRL_GEN_BIT = 0;

  // Request FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    CLEAR  = 2'd2
  } intc_state_e;

endpackage

// File: rtl/intc_arbiter.sv
// Combinational arbiter for intc_pc.
// Build option: INTC_RR_EN defined selects round-robin (search starts at
// ptr+1, wrapping); undefined selects fixed priority (lowest index wins).
// Ports:
//   req        in  N_CH  candidate requests
//   ptr        in  ID_W  last-served channel (round-robin only)
//   gnt_valid  out 1     any request present
//   gnt_id     out ID_W  winning channel
module intc_arbiter #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned ID_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic            gnt_valid,
  output logic [ID_W-1:0] gnt_id
);

  assign gnt_valid = |req;

`ifdef INTC_RR_EN
  int unsigned       start;
  int unsigned       off;
  logic [2*N_CH-1:0] dbl;

  // Rotate requests so ptr+1 lands at bit 0, priority-encode, rotate back
  always_comb begin
    start = (32'(ptr) + 32'd1) % N_CH;
    dbl   = {req, req} >> start;
    off   = 32'd0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (dbl[i]) off = unsigned'(i);
    end
    gnt_id = ID_W'((start + off) % N_CH);
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Fixed priority: lowest set index wins
  always_comb begin
    gnt_id = '0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (req[i]) gnt_id = ID_W'(i);
    end
  end
`endif

endmodule

// File: rtl/intc_pc.sv
// Parametrised memory-mapped interrupt controller.
// Edge-detects Done inputs into pending bits, masks them, arbitrates and
// raises a registered irq with a stable vector until acknowledged by iack.
// Build option: INTC_RR_EN selects round-robin arbitration (see intc_arbiter).
// Ports:
//   clk   in  1     system clock
//   rst   in  1     asynchronous active-low reset
//   A     in  2     register select (PENDING, MASK, VECTOR, CTRL)
//   WE    in  1     register write enable
//   WD    in  32    write data
//   RD    out 32    read data, combinational from A
//   Done  in  N_CH  channel completion inputs
//   iack  in  1     interrupt acknowledge pulse
//   irq   out 1     interrupt request, registered
//   addr  out ID_W  id of signalled channel, registered
module intc_pc
  import intc_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  parameter int unsigned ID_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      A,
  input  logic            WE,
  input  logic [31:0]     WD,
  output logic [31:0]     RD,
  input  logic [N_CH-1:0] Done,
  input  logic            iack,
  output logic            irq,
  output logic [ID_W-1:0] addr
);

  logic [N_CH-1:0] done_q;
  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] mask;
  logic            gen;
  logic [N_CH-1:0] set;
  logic [N_CH-1:0] w1c;
  logic [N_CH-1:0] clr_ack;
  logic [N_CH-1:0] cand;
  logic            gnt_valid;
  logic [ID_W-1:0] gnt_id;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] ptr_nxt;
  logic            irq_nxt;
  logic [ID_W-1:0] addr_nxt;
  intc_state_e     state;
  intc_state_e     state_nxt;

  logic unused_wd;
  assign unused_wd = ^WD;

  // Rising-edge detect, W1C strobes and candidate set
  always_comb begin
    set  = Done & ~done_q;
    w1c  = (WE && (A == INTC_PEND)) ? WD[N_CH-1:0] : '0;
    cand = gen ? (pending & mask) : '0;
  end

  intc_arbiter #(
    .N_CH (N_CH),
    .ID_W (ID_W)
  ) u_arb (
    .req       (cand),
    .ptr       (ptr),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Pending, mask and control registers; a new edge beats any clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q  <= '0;
      pending <= '0;
      mask    <= '0;
      gen     <= 1'b0;
    end else begin
      done_q  <= Done;
      pending <= (pending & ~(w1c | clr_ack)) | set;
      if (WE && (A == INTC_MASK)) mask <= WD[N_CH-1:0];
      if (WE && (A == INTC_CTRL)) gen  <= WD[CTRL_GEN_BIT];
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      irq   <= 1'b0;
      addr  <= '0;
      ptr   <= ID_W'(N_CH - 1);
    end else begin
      state <= state_nxt;
      irq   <= irq_nxt;
      addr  <= addr_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Next-state: grant in IDLE, hold in ASSERT, retire in CLEAR
  always_comb begin
    state_nxt = state;
    irq_nxt   = irq;
    addr_nxt  = addr;
    ptr_nxt   = ptr;
    clr_ack   = '0;
    case (state)
      IDLE: begin
        if (gnt_valid) begin
          irq_nxt   = 1'b1;
          addr_nxt  = gnt_id;
          state_nxt = ASSERT;
        end
      end
      ASSERT: begin
        if (iack) state_nxt = CLEAR;
      end
      CLEAR: begin
        clr_ack   = N_CH'(1) << addr;
        irq_nxt   = 1'b0;
        ptr_nxt   = addr;
        state_nxt = IDLE;
      end
      default: begin
        irq_nxt   = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Register read mux
  always_comb begin
    RD = '0;
    case (A)
      INTC_PEND: RD = 32'(pending);
      INTC_MASK: RD = 32'(mask);
      INTC_VEC:  RD = {irq, 23'b0, 8'(addr)};
      INTC_CTRL: RD = {31'b0, gen};
      default:   RD = '0;
    endcase
  end

endmodule

// File: tb/tb_intc_pc.sv
// Directed self-checking bench for intc_pc (N_CH=4).
module tb_intc_pc;
  import intc_pkg::*;

  logic        clk;
  logic        rst;
  logic [1:0]  A;
  logic        WE;
  logic [31:0] WD;
  logic [31:0] RD;
  logic [3:0]  Done;
  logic        iack;
  logic        irq;
  logic [1:0]  addr;

  int n_chk;
  int n_fail;

  intc_pc #(.N_CH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .WE   (WE),
    .WD   (WD),
    .RD   (RD),
    .Done (Done),
    .iack (iack),
    .irq  (irq),
    .addr (addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    A = a;
    #1;
    chk(tag, RD, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    A  = a;
    WD = d;
    WE = 1'b1;
    tick();
    WE = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] d);
    Done = d;
    tick();
    Done = 4'b0;
  endtask

  // iack sampled at edge k, back in IDLE with irq low after edge k+1
  task automatic serve();
    iack = 1'b1;
    tick();
    iack = 1'b0;
    tick();
  endtask

  logic seen;

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b0; A = 2'd0; WE = 1'b0; WD = '0; Done = '0; iack = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();

    // Reset defaults
    chk_reg("rst_pend", INTC_PEND, 32'h0);
    chk_reg("rst_mask", INTC_MASK, 32'h0);
    chk_reg("rst_vec",  INTC_VEC,  32'h0);
    chk_reg("rst_ctrl", INTC_CTRL, 32'h0);
    chk("rst_irq",  32'(irq),  32'h0);
    chk("rst_addr", 32'(addr), 32'h0);

    // iack in IDLE is ignored
    iack = 1'b1; tick(); iack = 1'b0; tick();
    chk("iack_idle_irq", 32'(irq), 32'h0);

    // Basic flow on channel 2
    wr(INTC_MASK, 32'hF);
    wr(INTC_CTRL, 32'h1);
    chk_reg("mask_rb", INTC_MASK, 32'hF);
    chk_reg("ctrl_rb", INTC_CTRL, 32'h1);
    pulse(4'b0100);
    chk_reg("basic_pend", INTC_PEND, 32'h4);
    chk("basic_irq_early", 32'(irq), 32'h0);
    tick();
    chk("basic_irq", 32'(irq), 32'h1);
    chk("basic_addr", 32'(addr), 32'h2);
    chk_reg("basic_vec", INTC_VEC, 32'h8000_0002);
    iack = 1'b1; tick(); iack = 1'b0;
    chk("basic_irq_in_clear", 32'(irq), 32'h1);
    tick();
    chk("basic_irq_drop", 32'(irq), 32'h0);
    chk_reg("basic_pend_clr", INTC_PEND, 32'h0);

    // Masking and level-held Done
    wr(INTC_MASK, 32'h1);
    Done = 4'b1000;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (irq) seen = 1'b1;
    end
    chk("mask_no_irq", 32'(seen), 32'h0);
    chk_reg("mask_pend", INTC_PEND, 32'h8);
    wr(INTC_MASK, 32'hF);
    tick();
    chk("level_irq", 32'(irq), 32'h1);
    chk("level_addr", 32'(addr), 32'h3);
    serve();
    chk("level_irq_drop", 32'(irq), 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (irq) seen = 1'b1;
    end
    chk("level_once", 32'(seen), 32'h0);
    chk_reg("level_pend", INTC_PEND, 32'h0);
    Done = 4'b0;
    tick();

    // GEN gates the candidate set; W1C clears pending
    wr(INTC_CTRL, 32'h0);
    pulse(4'b0001);
    tick(); tick(); tick();
    chk("gen_off_irq", 32'(irq), 32'h0);
    chk_reg("gen_off_pend", INTC_PEND, 32'h1);
    wr(INTC_PEND, 32'h1);
    chk_reg("w1c_pend", INTC_PEND, 32'h0);
    wr(INTC_CTRL, 32'h1);
    tick();
    chk("gen_on_irq", 32'(irq), 32'h0);

    // Priority between channels 1 and 3
    pulse(4'b1010);
    tick();
    chk("prio_a_irq", 32'(irq), 32'h1);
    chk("prio_a_addr", 32'(addr), 32'h1);
    serve();
    chk("prio_a_gap", 32'(irq), 32'h0);
    tick();
    chk("prio_b_irq", 32'(irq), 32'h1);
    chk("prio_b_addr", 32'(addr), 32'h3);
    serve();

    // Serve channel 1 alone, then pend 0 and 3 together
    pulse(4'b0010);
    tick();
    chk("last1_addr", 32'(addr), 32'h1);
    serve();
    pulse(4'b1001);
    tick();
    chk("prio_c_irq", 32'(irq), 32'h1);
`ifdef INTC_RR_EN
    chk("prio_c_addr", 32'(addr), 32'h3);
`else
    chk("prio_c_addr", 32'(addr), 32'h0);
`endif
    serve();
    tick();
`ifdef INTC_RR_EN
    chk("prio_d_addr", 32'(addr), 32'h0);
`else
    chk("prio_d_addr", 32'(addr), 32'h3);
`endif
    serve();

    // W1C of the channel being asserted: irq holds until iack
    pulse(4'b0100);
    tick();
    chk("w1c_as_addr", 32'(addr), 32'h2);
    wr(INTC_PEND, 32'h4);
    chk_reg("w1c_as_pend", INTC_PEND, 32'h0);
    chk("w1c_as_irq", 32'(irq), 32'h1);
    serve();
    chk("w1c_as_drop", 32'(irq), 32'h0);
    tick();
    chk("w1c_as_noreq", 32'(irq), 32'h0);

    // Collision: fresh edge on channel 0 during its CLEAR cycle
    pulse(4'b0001);
    tick();
    chk("coll_addr0", 32'(addr), 32'h0);
    iack = 1'b1; tick(); iack = 1'b0;
    Done = 4'b0001;
    tick();
    Done = 4'b0;
    chk_reg("coll_pend", INTC_PEND, 32'h1);
    chk("coll_irq_drop", 32'(irq), 32'h0);
    tick();
    chk("coll_irq", 32'(irq), 32'h1);
    chk("coll_addr", 32'(addr), 32'h0);

    // Async reset mid-ASSERT, off-edge
    #3;
    rst = 1'b0;
    #1;
    chk("arst_irq", 32'(irq), 32'h0);
    chk_reg("arst_pend", INTC_PEND, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    chk_reg("post_pend", INTC_PEND, 32'h0);
    chk_reg("post_mask", INTC_MASK, 32'h0);
    chk_reg("post_vec",  INTC_VEC,  32'h0);
    chk_reg("post_ctrl", INTC_CTRL, 32'h0);
    tick();
    chk("post_irq", 32'(irq), 32'h0);
    chk("post_addr", 32'(addr), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
